// File: rtl/post_cov_seq.sv
// post_cov_seq: posterior covariance update P_post = (I - K*H) * P_prior for
// DIM x DIM signed fixed-point matrices, computed with a single time-shared
// multiply-accumulate unit.
//
// Ports:
//   clk, rst_n        clock (rising edge) and synchronous active-low reset
//   start             one-cycle request, honoured only while idle
//   k_flat/h_flat/p_flat  K, H, P_prior; row-major, element (i,j) at
//                     [(i*DIM+j)*N +: N]
//   busy              high while either matrix product is being computed
//   done              one-cycle pulse once pp_flat holds the full result
//   ovf               sticky saturation flag for the current operation
//   pp_flat           P_post, same packing; updated element by element
//
// Configuration macros:
//   FXP_N / FXP_FRAC  default word width / fractional bits
//   POST_COV_SYM_EN   compute only the upper triangle of P_post and mirror
//                     it, giving a shorter second phase and exact symmetry
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module post_cov_seq #(
    parameter int N    = `FXP_N,
    parameter int FRAC = `FXP_FRAC,
    parameter int DIM  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIM*DIM*N-1:0]  k_flat,
    input  logic [DIM*DIM*N-1:0]  h_flat,
    input  logic [DIM*DIM*N-1:0]  p_flat,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [DIM*DIM*N-1:0]  pp_flat
);

    localparam int EL = DIM * DIM;
    localparam int IW = $clog2(EL);
    localparam int PW = 2 * N;
    localparam int AW = 2 * N + 2;
    localparam logic [1:0] DMAX = 2'(DIM - 1);

    localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);
    localparam logic signed [AW:0]   ONE  = (AW + 1)'(1) << FRAC;
    localparam logic signed [AW:0]   ZERO = '0;
    localparam logic signed [AW:0]   SMAX = ((AW + 1)'(1) << (N - 1)) - (AW + 1)'(1);
    localparam logic signed [AW:0]   SMIN = -((AW + 1)'(1) << (N - 1));

`ifdef POST_COV_SYM_EN
    localparam bit SYM = 1'b1;
`else
    localparam bit SYM = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, PH_A, PH_B, FIN} state_t;
    state_t state, state_nxt;

    // Captured operands, the intermediate M = I - K*H, and the result
    logic signed [N-1:0] kr [EL];
    logic signed [N-1:0] hr [EL];
    logic signed [N-1:0] pr [EL];
    logic signed [N-1:0] mr [EL];
    logic signed [N-1:0] ppr[EL];

    logic [1:0]           ci, cj, ck;
    logic signed [AW-1:0] acc;

    logic                 k_last, j_last, last_ijk, ph_b;
    logic [IW-1:0]        idx_ik, idx_kj, idx_ij, idx_ji;
    logic signed [N-1:0]  opa, opb;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_sum, acc_rnd, rnd;
    logic signed [AW:0]   diag_v, pre_sat;
    logic signed [N-1:0]  res;
    logic                 clamp;

    // MAC datapath: one product per cycle, round and saturate on the last k
    always_comb begin
        k_last   = (ck == DMAX);
        j_last   = (cj == DMAX);
        last_ijk = (ci == DMAX) && j_last && k_last;
        ph_b     = (state == PH_B);

        idx_ik = IW'(int'(ci) * DIM + int'(ck));
        idx_kj = IW'(int'(ck) * DIM + int'(cj));
        idx_ij = IW'(int'(ci) * DIM + int'(cj));
        idx_ji = IW'(int'(cj) * DIM + int'(ci));

        opa = ph_b ? mr[idx_ik] : kr[idx_ik];
        opb = ph_b ? pr[idx_kj] : hr[idx_kj];

        prod    = PW'(opa) * PW'(opb);
        acc_sum = acc + AW'(prod);
        acc_rnd = acc_sum + HALF;
        rnd     = acc_rnd >>> FRAC;

        // Phase A subtracts from the identity; phase B passes the dot product
        diag_v  = (ci == cj) ? ONE : ZERO;
        pre_sat = ph_b ? (AW + 1)'(rnd) : diag_v - (AW + 1)'(rnd);

        clamp = 1'b0;
        if (pre_sat > SMAX) begin
            res   = SMAX[N-1:0];
            clamp = 1'b1;
        end else if (pre_sat < SMIN) begin
            res   = SMIN[N-1:0];
            clamp = 1'b1;
        end else begin
            res = pre_sat[N-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = PH_A;
            PH_A: begin
                busy = 1'b1;
                if (last_ijk) state_nxt = PH_B;
            end
            PH_B: begin
                busy = 1'b1;
                // Upper-triangle walk also ends on (DIM-1, DIM-1, DIM-1)
                if (last_ijk) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ci    <= '0;
            cj    <= '0;
            ck    <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            for (int e = 0; e < EL; e++) begin
                kr[e]  <= '0;
                hr[e]  <= '0;
                pr[e]  <= '0;
                mr[e]  <= '0;
                ppr[e] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int e = 0; e < EL; e++) begin
                            kr[e] <= k_flat[e*N +: N];
                            hr[e] <= h_flat[e*N +: N];
                            pr[e] <= p_flat[e*N +: N];
                        end
                        ovf <= 1'b0;
                        acc <= '0;
                        ci  <= '0;
                        cj  <= '0;
                        ck  <= '0;
                    end
                end
                PH_A, PH_B: begin
                    acc <= k_last ? '0 : acc_sum;
                    if (k_last) begin
                        if (ph_b) begin
                            ppr[idx_ij] <= res;
                            if (SYM && (ci != cj)) ppr[idx_ji] <= res;
                        end else begin
                            mr[idx_ij] <= res;
                        end
                        if (clamp) ovf <= 1'b1;
                    end
                    if (last_ijk) begin
                        ci <= '0;
                        cj <= '0;
                        ck <= '0;
                    end else if (k_last) begin
                        ck <= '0;
                        if (j_last) begin
                            ci <= ci + 2'd1;
                            // Triangular walk restarts each row on the diagonal
                            cj <= (SYM && ph_b) ? ci + 2'd1 : 2'd0;
                        end else begin
                            cj <= cj + 2'd1;
                        end
                    end else begin
                        ck <= ck + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar e = 0; e < EL; e++) begin : g_out
        assign pp_flat[e*N +: N] = ppr[e];
    end

endmodule

// File: tb/tb_post_cov_seq.sv
// Self-checking bench for post_cov_seq: DIM=2, 3 and 4 instances, a matrix
// reference model feeding a scoreboard queue, latency/busy/ovf checks,
// mid-operation reset and ignored retrigger.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module tb_post_cov_seq;

    localparam int N    = `FXP_N;
    localparam int FRAC = `FXP_FRAC;
    localparam int S    = 1 << FRAC;
    localparam longint MAXV = (64'sd1 <<< (N - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (N - 1));
`ifdef POST_COV_SYM_EN
    localparam bit SYM = 1'b1;
`else
    localparam bit SYM = 1'b0;
`endif

    typedef int mat_t[16];
    typedef struct packed {
        logic [15:0][31:0] pp;
        logic              ov;
        logic [15:0]       lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start2, start3, start4;
    logic [4*N-1:0]  k2, h2, p2, pp2;
    logic [9*N-1:0]  k3, h3, p3, pp3;
    logic [16*N-1:0] k4, h4, p4, pp4;
    logic busy2, done2, ovf2, busy3, done3, ovf3, busy4, done4, ovf4;

    int   cyc = 0;
    int   c0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    mat_t Km, Hm, Pm, Rm;
    bit   m_ov;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    post_cov_seq #(.N(N), .FRAC(FRAC), .DIM(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .k_flat(k2), .h_flat(h2),
        .p_flat(p2), .busy(busy2), .done(done2), .ovf(ovf2), .pp_flat(pp2));
    post_cov_seq #(.N(N), .FRAC(FRAC), .DIM(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .k_flat(k3), .h_flat(h3),
        .p_flat(p3), .busy(busy3), .done(done3), .ovf(ovf3), .pp_flat(pp3));
    post_cov_seq #(.N(N), .FRAC(FRAC), .DIM(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .k_flat(k4), .h_flat(h4),
        .p_flat(p4), .busy(busy4), .done(done4), .ovf(ovf4), .pp_flat(pp4));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic get_done(input int d);
        case (d) 2: return done2; 3: return done3; default: return done4; endcase
    endfunction
    function automatic logic get_busy(input int d);
        case (d) 2: return busy2; 3: return busy3; default: return busy4; endcase
    endfunction
    function automatic logic get_ovf(input int d);
        case (d) 2: return ovf2; 3: return ovf3; default: return ovf4; endcase
    endfunction
    function automatic logic get_ppnz(input int d);
        case (d) 2: return |pp2; 3: return |pp3; default: return |pp4; endcase
    endfunction
    function automatic longint get_pp(input int d, input int e);
        case (d)
            2:       return longint'($signed(pp2[e*N +: N]));
            3:       return longint'($signed(pp3[e*N +: N]));
            default: return longint'($signed(pp4[e*N +: N]));
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d) 2: start2 = v; 3: start3 = v; default: start4 = v; endcase
    endtask

    function automatic longint sat(input longint x);
        if (x > MAXV) begin m_ov = 1'b1; return MAXV; end
        if (x < MINV) begin m_ov = 1'b1; return MINV; end
        return x;
    endfunction

    // Reference: M = I - K*H, then P_post = M*P, rounding half up after each dot product
    task automatic model(input int d, output mat_t R);
        longint m[16];
        longint acc, r, v;
        m_ov = 1'b0;
        R = '{default: 0};
        for (int e = 0; e < 16; e++) m[e] = 0;
        for (int i = 0; i < d; i++)
            for (int j = 0; j < d; j++) begin
                acc = 0;
                for (int k = 0; k < d; k++) acc += longint'(Km[i*d+k]) * longint'(Hm[k*d+j]);
                r = (acc + longint'(S / 2)) >>> FRAC;
                m[i*d+j] = sat(((i == j) ? longint'(S) : 0) - r);
            end
        for (int i = 0; i < d; i++)
            for (int j = (SYM ? i : 0); j < d; j++) begin
                acc = 0;
                for (int k = 0; k < d; k++) acc += m[i*d+k] * longint'(Pm[k*d+j]);
                r = (acc + longint'(S / 2)) >>> FRAC;
                v = sat(r);
                R[i*d+j] = int'(v);
                if (SYM) R[j*d+i] = int'(v);
            end
    endtask

    task automatic diag(input int d, input int v, output mat_t m);
        m = '{default: 0};
        for (int i = 0; i < d; i++) m[i*d+i] = v;
    endtask

    task automatic rnd_mat(input int d, output mat_t m);
        m = '{default: 0};
        for (int e = 0; e < d*d; e++) m[e] = int'($urandom_range(0, 2*S)) - S;
    endtask

    task automatic launch(input int d, input bit push);
        mat_t R;
        exp_t x;
        model(d, R);
        x = '0;
        for (int e = 0; e < 16; e++) x.pp[e] = R[e];
        x.ov  = m_ov;
        x.lat = SYM ? 16'(d*d*d + d*d*(d+1)/2 + 2) : 16'(2*d*d*d + 2);
        if (push) sb.push_back(x);
        @(negedge clk);
        case (d)
            2: for (int e = 0; e < 4; e++) begin
                k2[e*N +: N] = Km[e][N-1:0]; h2[e*N +: N] = Hm[e][N-1:0]; p2[e*N +: N] = Pm[e][N-1:0];
            end
            3: for (int e = 0; e < 9; e++) begin
                k3[e*N +: N] = Km[e][N-1:0]; h3[e*N +: N] = Hm[e][N-1:0]; p3[e*N +: N] = Pm[e][N-1:0];
            end
            default: for (int e = 0; e < 16; e++) begin
                k4[e*N +: N] = Km[e][N-1:0]; h4[e*N +: N] = Hm[e][N-1:0]; p4[e*N +: N] = Pm[e][N-1:0];
            end
        endcase
        set_start(d, 1'b1);
        c0 = cyc;
    endtask

    // Wait (bounded) for done, then pop the scoreboard and compare.
    // retrig != 0 pulses start again in that cycle with garbage inputs.
    task automatic finish_op(input int d, input int retrig);
        exp_t x;
        int   n;
        bit   bz_ok;
        bz_ok = 1'b1;
        n = 0;
        @(negedge clk);
        set_start(d, 1'b0);
        while (!get_done(d) && n < 300) begin
            if (!get_busy(d)) bz_ok = 1'b0;
            @(negedge clk);
            n++;
            if (retrig != 0) begin
                set_start(d, (cyc - c0 + 1) == retrig);
                if ((cyc - c0 + 1) == retrig) begin
                    k4 = ~k4;
                    p4 = ~p4;
                end
            end
        end
        x = sb.pop_front();
        chk($sformatf("d%0d_done_seen", d), get_done(d), 1);
        chk($sformatf("d%0d_latency", d), cyc - c0 + 1, x.lat);
        chk($sformatf("d%0d_busy_between", d), bz_ok, 1);
        chk($sformatf("d%0d_busy_at_done", d), get_busy(d), 0);
        chk($sformatf("d%0d_ovf", d), get_ovf(d), x.ov);
        for (int e = 0; e < d*d; e++)
            chk($sformatf("d%0d_pp[%0d]", d, e), get_pp(d, e), longint'($signed(x.pp[e])));
        @(negedge clk);
        chk($sformatf("d%0d_done_pulse", d), get_done(d), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        start2 = 1'b0; start3 = 1'b0; start4 = 1'b0;
        k2 = '0; h2 = '0; p2 = '0;
        k3 = '0; h3 = '0; p3 = '0;
        k4 = '0; h4 = '0; p4 = '0;
        repeat (3) @(negedge clk);
        for (int d = 2; d <= 4; d++) begin
            chk($sformatf("rst_busy_d%0d", d), get_busy(d), 0);
            chk($sformatf("rst_done_d%0d", d), get_done(d), 0);
            chk($sformatf("rst_ovf_d%0d", d), get_ovf(d), 0);
            chk($sformatf("rst_pp_d%0d", d), get_ppnz(d), 0);
        end
        rst_n = 1'b1;

        // K = I/2, H = I, P = I
        diag(2, S/2, Km); diag(2, S, Hm); diag(2, S, Pm);
        launch(2, 1'b1); finish_op(2, 0);
        chk("t1_pp00", get_pp(2, 0), S/2);
        chk("t1_pp01", get_pp(2, 1), 0);

        // K = 0 passes P through unchanged
        Km = '{default: 0}; rnd_mat(3, Hm);
        Pm = '{S, 2, 3, 2, S, 5, 3, 5, S, 0, 0, 0, 0, 0, 0, 0};
        launch(3, 1'b1); finish_op(3, 0);
        chk("t2_pp12", get_pp(3, 5), 5);

        // Half-LSB product rounds up
        Km = '{default: 0}; Km[0] = 1;
        Hm = '{default: 0}; Hm[0] = S/2;
        diag(2, S, Pm);
        launch(2, 1'b1); finish_op(2, 0);
        chk("t3_pp00", get_pp(2, 0), S - 1);
        chk("t3_pp11", get_pp(2, 3), S);

        // M = 1.5*I against a near-full-scale P saturates, then clears
        diag(2, -S/2, Km); diag(2, S, Hm); diag(2, int'(MAXV), Pm);
        launch(2, 1'b1); finish_op(2, 0);
        chk("t4_ovf", get_ovf(2), 1);
        chk("t4_pp00", get_pp(2, 0), MAXV);
        Km = '{default: 0};
        launch(2, 1'b1); finish_op(2, 0);
        chk("t4b_ovf", get_ovf(2), 0);

        // Random pattern
        rnd_mat(3, Km); rnd_mat(3, Hm); rnd_mat(3, Pm);
        launch(3, 1'b1); finish_op(3, 0);

        // Non-symmetric K with H = I
        Km = '{10, -20, 30, 40, 5, -6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0};
        diag(3, S, Hm);
        Pm = '{S, 2, 3, 2, S, 5, 3, 5, S, 0, 0, 0, 0, 0, 0, 0};
        launch(3, 1'b1); finish_op(3, 0);
`ifdef POST_COV_SYM_EN
        model(3, Rm);
        for (int i = 0; i < 3; i++)
            for (int j = i + 1; j < 3; j++)
                chk($sformatf("sym_pp%0d%0d", j, i), get_pp(3, j*3+i), Rm[i*3+j]);
`endif

        // DIM=4 full run leaves a non-zero result behind
        rnd_mat(4, Km); rnd_mat(4, Hm); rnd_mat(4, Pm);
        launch(4, 1'b1); finish_op(4, 0);

        // Reset at cycle 40 aborts
        launch(4, 1'b0);
        @(negedge clk);
        start4 = 1'b0;
        while ((cyc - c0 + 1) < 40) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy4, 0);
        chk("abort_done", done4, 0);
        chk("abort_ovf", ovf4, 0);
        chk("abort_pp", get_ppnz(4), 0);
        cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (done4) cnt++;
        end
        chk("abort_no_done", cnt, 0);

        // Retrigger while busy is ignored
        rnd_mat(4, Km); rnd_mat(4, Hm); rnd_mat(4, Pm);
        launch(4, 1'b1); finish_op(4, 20);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done4) cnt++;
        end
        chk("retrig_extra_done", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
